// File: rtl/mips_disp_pkg.sv
// Shared types, segment constants and the hex-to-segment decoder for the
// MIPS board seven-segment display controller.
package mips_disp_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2
    } disp_state_e;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter. A start pulse loads the
// value; DATA_W shifts follow, MSB first. o_done is high in the cycle whose
// clock edge performs the final shift, so o_bcd is final right after it.
// BCD digits above NUM_DIGITS are dropped; the caller flags that as overflow.
module bin2bcd_seq #(
    parameter int DATA_W     = 16,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [DATA_W-1:0]       i_value,
    output logic [4*NUM_DIGITS-1:0] o_bcd,
    output logic                    o_done
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] r_shift;
    logic [BCD_W-1:0]  r_bcd;
    logic [BCD_W-1:0]  w_adj;
    logic [CNT_W-1:0]  r_cnt;

    // Add 3 to every nibble >= 5 ahead of the shift
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Load on start, then shift one bit per cycle until the counter empties
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
        end else if (i_start) begin
            r_shift <= i_value;
            r_bcd   <= '0;
            r_cnt   <= CNT_W'(DATA_W);
        end else if (r_cnt != '0) begin
            r_bcd   <= BCD_W'({w_adj, r_shift[DATA_W-1]});
            r_shift <= r_shift << 1;
            r_cnt   <= r_cnt - CNT_W'(1);
        end
    end

    assign o_bcd  = r_bcd;
    assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mips_seg_display.sv
// Scanned N-digit seven-segment display for the MIPS board test top.
// Continuously snapshots the selected channel, renders it in hex or
// unsigned decimal and multiplexes the digits onto Seg/Anode.
//
//   state   | meaning
//   S_IDLE  | snapshot channel value and mode; start BCD conversion if decimal
//   S_SHIFT | double-dabble running, DATA_W cycles
//   S_LATCH | write digit registers and Overflow, drop Busy
module mips_seg_display
    import mips_disp_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 16,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int LZB         = 1
) (
    input  logic                                        Clk_O,
    input  logic                                        Reset,
    input  logic [NUM_CH*DATA_W-1:0]                    Values,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] ChSel,
    input  logic                                        DecMode,
    output logic [6:0]                                  Seg,
    output logic [NUM_DIGITS-1:0]                       Anode,
    output logic                                        Busy,
    output logic                                        Overflow
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int RC_W  = $clog2(REFRESH_DIV);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam logic [63:0] DEC_LIMIT = 64'(10 ** NUM_DIGITS);

    disp_state_e             r_state, w_state_next;
    logic [DATA_W-1:0]       w_sel_value;
    logic [DATA_W-1:0]       r_snap;
    logic                    r_dec;
    logic                    r_ovf_snap;
    logic                    w_start;
    logic                    w_bcd_done;
    logic [BCD_W-1:0]        w_bcd;
    logic [BCD_W-1:0]        w_hex_ext;
    logic [6:0]              w_digit_code [NUM_DIGITS];
    logic [6:0]              r_digit      [NUM_DIGITS];
    logic [RC_W-1:0]         r_refresh;
    logic [IDX_W-1:0]        r_idx;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic                    r_busy;
    logic                    r_overflow;

    // Channel select; any index without a matching channel falls back to channel 0
    always_comb begin
        w_sel_value = Values[0 +: DATA_W];
        for (int k = 0; k < NUM_CH; k++) begin
            if (ChSel == CH_W'(k)) begin
                w_sel_value = Values[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_start = (r_state == S_IDLE) && DecMode;

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .i_clk   (Clk_O),
        .i_reset (Reset),
        .i_start (w_start),
        .i_value (w_sel_value),
        .o_bcd   (w_bcd),
        .o_done  (w_bcd_done)
    );

    // FSM state register
    always_ff @(posedge Clk_O) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // FSM next-state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = DecMode ? S_SHIFT : S_LATCH;
            S_SHIFT: if (w_bcd_done) w_state_next = S_LATCH;
            S_LATCH: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_hex_ext = BCD_W'(r_snap);

    // Per-digit segment codes: hex nibbles, or BCD with dashes/leading-zero blanking
    always_comb begin
        logic seen_nz;
        seen_nz = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_digit_code[i] = SEG_BLANK;
        end
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (!r_dec) begin
                w_digit_code[i] = hex_to_seg(w_hex_ext[4*i +: 4]);
            end else begin
                if (w_bcd[4*i +: 4] != 4'd0) seen_nz = 1'b1;
                if (r_ovf_snap)                              w_digit_code[i] = SEG_DASH;
                else if ((LZB != 0) && (i != 0) && !seen_nz) w_digit_code[i] = SEG_BLANK;
                else                                         w_digit_code[i] = hex_to_seg(w_bcd[4*i +: 4]);
            end
        end
    end

    // Snapshot, Busy, digit registers and Overflow follow the FSM phase
    always_ff @(posedge Clk_O) begin
        if (Reset) begin
            r_snap     <= '0;
            r_dec      <= 1'b0;
            r_ovf_snap <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= SEG_BLANK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_snap     <= w_sel_value;
                    r_dec      <= DecMode;
                    r_ovf_snap <= DecMode && (64'(w_sel_value) >= DEC_LIMIT);
                    r_busy     <= DecMode;
                end
                S_LATCH: begin
                    for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= w_digit_code[i];
                    r_overflow <= r_ovf_snap;
                    r_busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Refresh timer and digit scan; Seg and Anode are registered together
    always_ff @(posedge Clk_O) begin
        if (Reset) begin
            r_refresh <= '0;
            r_idx     <= '0;
            r_seg     <= SEG_BLANK;
            r_anode   <= '1;
        end else begin
            if (r_refresh == RC_W'(REFRESH_DIV - 1)) begin
                r_refresh <= '0;
                r_idx     <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_refresh <= r_refresh + RC_W'(1);
            end
            r_anode <= ~(NUM_DIGITS'(1) << r_idx);
            r_seg   <= r_digit[r_idx];
        end
    end

    assign Seg      = r_seg;
    assign Anode    = r_anode;
    assign Busy     = r_busy;
    assign Overflow = r_overflow;

endmodule

// File: tb/tb_mips_seg_display.sv
// Directed bench for mips_seg_display with a short refresh period.
module tb_mips_seg_display;
    import mips_disp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] values;
    logic [1:0]  chsel;
    logic        decmode;
    logic [6:0]  seg;
    logic [3:0]  anode;
    logic        busy;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_seg_display #(
        .NUM_CH      (4),
        .DATA_W      (16),
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .LZB         (1)
    ) dut (
        .Clk_O    (clk),
        .Reset    (reset),
        .Values   (values),
        .ChSel    (chsel),
        .DecMode  (decmode),
        .Seg      (seg),
        .Anode    (anode),
        .Busy     (busy),
        .Overflow (overflow)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Align to the start of digit 0 and check a full scan round, 4 cycles per digit
    task automatic scan_check(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an  [4];
        logic [3:0] prev;
        logic       found;
        exp_seg = '{e0, e1, e2, e3};
        exp_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
        found   = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev = anode;
            tick(1);
            if (anode == 4'hE && prev == 4'h7) found = 1'b1;
        end
        chk({tag, " align"}, 32'(found), 32'd1);
        if (found) begin
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < 4; c++) begin
                    chk({tag, " anode"}, 32'(anode), 32'(exp_an[d]));
                    chk({tag, " seg"},   32'(seg),   32'(exp_seg[d]));
                    tick(1);
                end
            end
            chk({tag, " wrap"}, 32'(anode), 32'hE);
        end
    endtask

    // Check Seg against the expected code of whichever digit is currently enabled
    task automatic disp_check(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3, input int n);
        logic [6:0] e;
        logic       ok_an;
        for (int k = 0; k < n; k++) begin
            ok_an = 1'b1;
            case (anode)
                4'hE: e = e0;
                4'hD: e = e1;
                4'hB: e = e2;
                4'h7: e = e3;
                default: begin e = 7'h7F; ok_an = 1'b0; end
            endcase
            chk({tag, " onecold"}, 32'(ok_an), 32'd1);
            chk({tag, " seg"}, 32'(seg), 32'(e));
            tick(1);
        end
    endtask

    task automatic wait_busy_rise(input string tag);
        logic prev;
        logic found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            prev = busy;
            tick(1);
            if (busy && !prev) found = 1'b1;
        end
        chk({tag, " busy rise"}, 32'(found), 32'd1);
    endtask

    task automatic wait_busy_fall(input string tag);
        logic found;
        found = !busy;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (!busy) found = 1'b1;
        end
        chk({tag, " busy fall"}, 32'(found), 32'd1);
    endtask

    initial begin
        int n_busy;

        // 1: reset state, scan start and hex latency
        reset   = 1'b1;
        values  = 64'h0;
        chsel   = 2'd0;
        decmode = 1'b0;
        tick(3);
        chk("rst seg", 32'(seg), 32'h7F);
        chk("rst anode", 32'(anode), 32'hF);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick(1);
        chk("scan first anode", 32'(anode), 32'hE);
        chk("hex not yet visible", 32'(seg), 32'h7F);
        tick(1);
        chk("hex latency -1", 32'(seg), 32'h7F);
        tick(1);
        chk("hex latency 2", 32'(seg), 32'h40);
        tick(1);
        chk("digit0 hold", 32'(anode), 32'hE);
        tick(1);
        chk("first wrap digit1", 32'(anode), 32'hD);

        // 2: hex display
        values[15:0] = 16'h1A3F;
        tick(10);
        scan_check("hex 1A3F", 7'h0E, 7'h30, 7'h08, 7'h79);
        chk("hex busy", 32'(busy), 32'd0);
        chk("hex ovf", 32'(overflow), 32'd0);

        // 3: decimal 1234 on channel 1
        values[31:16] = 16'd1234;
        chsel   = 2'd1;
        decmode = 1'b1;
        wait_busy_rise("dec1234");
        n_busy = 0;
        while (busy && n_busy < 60) begin
            n_busy++;
            tick(1);
        end
        chk("busy length", 32'(n_busy), 32'd17);
        tick(1);
        chk("busy restart", 32'(busy), 32'd1);
        tick(30);
        scan_check("dec 1234", 7'h19, 7'h30, 7'h24, 7'h79);
        chk("dec1234 ovf", 32'(overflow), 32'd0);

        // 4: leading-zero blanking
        values[31:16] = 16'd7;
        tick(40);
        scan_check("dec 7", 7'h78, 7'h7F, 7'h7F, 7'h7F);
        values[31:16] = 16'd0;
        tick(40);
        scan_check("dec 0", 7'h40, 7'h7F, 7'h7F, 7'h7F);

        // 5: overflow, then back to hex
        values[31:16] = 16'd12345;
        tick(40);
        chk("ovf set", 32'(overflow), 32'd1);
        scan_check("dec ovf", 7'h3F, 7'h3F, 7'h3F, 7'h3F);
        decmode = 1'b0;
        tick(40);
        chk("ovf clear hex", 32'(overflow), 32'd0);
        scan_check("hex 3039", 7'h10, 7'h30, 7'h40, 7'h30);

        // 6: ChSel change mid-shift is ignored until the next snapshot
        values[31:16] = 16'd1234;
        values[47:32] = 16'd42;
        decmode = 1'b1;
        wait_busy_rise("chsel");
        tick(5);
        chsel = 2'd2;
        wait_busy_fall("chsel old");
        tick(1);
        disp_check("old ch latched", 7'h19, 7'h30, 7'h24, 7'h79, 4);
        wait_busy_fall("chsel new");
        tick(1);
        disp_check("new ch latched", 7'h24, 7'h19, 7'h7F, 7'h7F, 4);

        // Reset in the middle of a conversion
        wait_busy_rise("midrst");
        tick(7);
        reset = 1'b1;
        tick(1);
        chk("midrst seg", 32'(seg), 32'h7F);
        chk("midrst anode", 32'(anode), 32'hF);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst ovf", 32'(overflow), 32'd0);
        chk("midrst state", 32'(dut.r_state), 32'(S_IDLE));
        reset = 1'b0;
        tick(40);
        scan_check("after rst 42", 7'h24, 7'h19, 7'h7F, 7'h7F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
